vregs_enum_parse: RTL
=====================

# vregs_enum_parse

ASCII-to-enum parser for the En_ExEnum register type: the inverse of the AUTOASCIIENUM debug decode. It accepts a byte stream of space-padded enum names, e.g. from a debug UART or testbench command channel. For each delimited token it emits the matching EP_ExEnum_ code, or an error flag. It sits between a byte-stream source and any block that writes an En_ExEnum register.

## Interface

Parameters:
- MAXLEN, 8: maximum token length in characters. Fixes the 64-bit name buffer; not overridable.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- ch_valid  in  1  input byte valid
- ch_data  in  8  input ASCII byte
- ch_ready  out  1  parser can accept a byte; byte transfers when ch_valid && ch_ready
- out_valid  out  1  result valid; held until accepted
- out_ready  in  1  consumer accepts the result
- out_enum  out  4  decoded En_ExEnum code; 4'h0 when out_error
- out_error  out  1  token unrecognised or overlong

## Operation

Character classes:
- Delimiters: 0x20 space, 0x0A LF, 0x0D CR, 0x00 NUL.
- Any other byte is a token character.

Name buffer:
- 64 bits, preset to eight spaces ("        ").
- Character k of a token (k = 0..7) is written to byte lane 7-k (bits 63-8k : 56-8k).
- The buffer is therefore directly comparable with the space-padded decode strings.

States:
- IDLE
  - ch_ready=1.
  - Delimiter: ignored; empty tokens produce no result.
  - Token char: written at k=0, cnt=1, go to ACCUM.
- ACCUM
  - ch_ready=1.
  - Token char with cnt<8: written at k=cnt, cnt++.
  - Token char with cnt==8: set ovf, go to SKIP.
  - Delimiter: go to MATCH.
- SKIP
  - ch_ready=1.
  - Token chars are discarded.
  - Delimiter: go to MATCH.
- MATCH
  - ch_ready=0.
  - One cycle: compare the buffer against the name table and register out_enum/out_error.
  - Go to OUT.
- OUT
  - ch_ready=0, out_valid=1.
  - On out_ready: clear the buffer to spaces, cnt=0, ovf=0, go to IDLE.

Name table (exact, lowercase):
- "one     " -> 4'h1 (EP_ExEnum_ONE)
- "two     " -> 4'h2 (EP_ExEnum_TWO)
- "five    " -> 4'h5 (EP_ExEnum_FIVE)
- "fourteen" -> 4'hE (EP_ExEnum_FOURTEEN)
- No match, or ovf set: out_error=1, out_enum=4'h0.

Boundary rules:
- An 8-character token followed by a delimiter is legal ("fourteen").
- A 9th token character forces an error result.
- A prefix match is not a match: "fiv" -> error.
- A token containing an embedded space cannot occur, because space always delimits.

## Timing

- Reset values: state=IDLE, ch_ready=1, out_valid=0, out_enum=4'h0, out_error=0, buffer=spaces, cnt=0, ovf=0.
- Delimiter accepted in cycle N: MATCH in cycle N+1, out_valid=1 from cycle N+2.
- out_enum and out_error are stable while out_valid=1 and out_ready=0.
- Output transfer in cycle M: ch_ready=1 in cycle M+1. Throughput is at most one token per (len+3) cycles.
- ch_ready is a registered function of state only. It does not depend on ch_valid or out_ready.
- Reset asserted in any state, including mid-token or in OUT with a pending result:
  - the partial token or result is discarded;
  - the block returns to IDLE on the next clock;
  - no out_valid pulse is emitted.

## Configuration

- VREGS_ENUM_PARSE_CASEFOLD_EN
  - Defined: token characters 0x41–0x5A are mapped to 0x61–0x7A before entering the buffer, so "FIVE" -> 4'h5.
  - Undefined: bytes are stored unmodified, and any uppercase character yields out_error.

## Structure

- EP_ExEnum_* codes come from the shared vregs_spec_param.v include. They are never redefined locally.
- The name strings are also defined in that shared include, as 64-bit constants, so the AUTOASCIIENUM decode and this parser use identical spellings.
- One sub-module, vregs_enum_match:
  - combinational;
  - inputs: the 64-bit buffer and ovf;
  - outputs: enum code and error.
- The top level holds the FSM, cnt, the buffer, the case-fold logic and the output registers.

## Test plan

- Reset, then bytes "five\n" with out_ready=1 -> out_valid in the cycle 2 after the LF, out_enum=4'h5, out_error=0. A single result only.
- "  one two " (leading and double spaces) -> exactly two results, 4'h1 then 4'h2. Empty tokens produce nothing.
- "fourteen " -> 4'hE; "fourteens " -> out_error=1, out_enum=4'h0. Bytes after the 8th are discarded until the space.
- "fiv " and "sixx " -> out_error=1 each.
- "FIVE ":
  - with VREGS_ENUM_PARSE_CASEFOLD_EN -> 4'h5;
  - without it -> out_error=1.
- Backpressure:
  - Hold out_ready=0 for 10 cycles after the "two " result: out_valid, out_enum=4'h2 and ch_ready=0 all stay stable.
  - Then assert reset mid-way through the next token "on": state is IDLE next clock, out_valid=0, and a following "one " yields 4'h1.

Source files
------------

// File: rtl/vregs_enum_parse_pkg.sv
// Shared types and constants for the En_ExEnum ASCII parser: enum codes,
// space-padded name strings, FSM state encoding and character helpers.
package vregs_enum_parse_pkg;

  localparam int MAXLEN = 8;
  localparam int BUF_W  = 8 * MAXLEN;

  // En_ExEnum register codes; these are the single source of truth for both
  // the AUTOASCIIENUM debug decode and this parser.
  localparam logic [3:0] EP_ExEnum_ONE      = 4'h1;
  localparam logic [3:0] EP_ExEnum_TWO      = 4'h2;
  localparam logic [3:0] EP_ExEnum_FIVE     = 4'h5;
  localparam logic [3:0] EP_ExEnum_FOURTEEN = 4'hE;

  // Name strings as space-padded 64-bit constants, first character in the MSB lane.
  localparam logic [BUF_W-1:0] NAME_ONE      = "one     ";
  localparam logic [BUF_W-1:0] NAME_TWO      = "two     ";
  localparam logic [BUF_W-1:0] NAME_FIVE     = "five    ";
  localparam logic [BUF_W-1:0] NAME_FOURTEEN = "fourteen";
  localparam logic [BUF_W-1:0] NAME_BLANK    = "        ";

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_SKIP,
    ST_MATCH,
    ST_OUT
  } state_e;

  function automatic logic is_delim(input logic [7:0] c);
    return (c == 8'h20) || (c == 8'h0A) || (c == 8'h0D) || (c == 8'h00);
  endfunction

  function automatic logic [7:0] fold_case(input logic [7:0] c);
    if (c >= 8'h41 && c <= 8'h5A) return c | 8'h20;
    return c;
  endfunction

endpackage

// File: rtl/vregs_enum_match.sv
// Combinational name-table lookup: maps a space-padded 64-bit token buffer
// to its En_ExEnum code, flagging unknown or overlong tokens as errors.
module vregs_enum_match
  import vregs_enum_parse_pkg::*;
(
  input  logic [BUF_W-1:0] name_buf,
  input  logic             ovf,
  output logic [3:0]       code,
  output logic             error
);

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    code  = 4'h0;
    error = 1'b1;
    if (!ovf) begin
      case (name_buf)
        NAME_ONE:      begin code = EP_ExEnum_ONE;      error = 1'b0; end
        NAME_TWO:      begin code = EP_ExEnum_TWO;      error = 1'b0; end
        NAME_FIVE:     begin code = EP_ExEnum_FIVE;     error = 1'b0; end
        NAME_FOURTEEN: begin code = EP_ExEnum_FOURTEEN; error = 1'b0; end
        default:       begin code = 4'h0;               error = 1'b1; end
      endcase
    end
  end

endmodule

// File: rtl/vregs_enum_parse.sv
// Byte-stream to En_ExEnum parser. Define VREGS_ENUM_PARSE_CASEFOLD_EN to
// fold uppercase token characters to lowercase before matching.
module vregs_enum_parse
  import vregs_enum_parse_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       ch_valid,
  input  logic [7:0] ch_data,
  output logic       ch_ready,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_enum,
  output logic       out_error
);

  state_e           state;
  state_e           state_next;
  logic [3:0]       cnt;
  logic             ovf;
  logic [BUF_W-1:0] name_buf;
  logic [2:0]       lane;
  logic [7:0]       ch_byte;
  logic             accept;
  logic             delim;
  logic [3:0]       match_code;
  logic             match_error;

  assign accept = ch_valid && ch_ready;
  assign delim  = is_delim(ch_data);
  // Character k of the token lands in byte lane 7-k so the buffer reads like the name string.
  assign lane   = 3'd7 - cnt[2:0];

`ifdef VREGS_ENUM_PARSE_CASEFOLD_EN
  assign ch_byte = fold_case(ch_data);
`else
  assign ch_byte = ch_data;
`endif

  vregs_enum_match u_match (
    .name_buf (name_buf),
    .ovf      (ovf),
    .code     (match_code),
    .error    (match_error)
  );

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (accept && !delim) state_next = ST_ACCUM;
      ST_ACCUM: begin
        if (accept) begin
          if (delim)                     state_next = ST_MATCH;
          else if (cnt == 4'(MAXLEN))    state_next = ST_SKIP;
        end
      end
      ST_SKIP:  if (accept && delim) state_next = ST_MATCH;
      ST_MATCH: state_next = ST_OUT;
      ST_OUT:   if (out_ready) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Handshake outputs decode the state register only.
  always_comb begin
    ch_ready  = (state == ST_IDLE) || (state == ST_ACCUM) || (state == ST_SKIP);
    out_valid = (state == ST_OUT);
  end

  // NOTE: the name buffer is a plain register, so resetting it to spaces is cheap and required.
  always_ff @(posedge clk) begin
    if (reset) begin
      name_buf  <= NAME_BLANK;
      cnt       <= 4'd0;
      ovf       <= 1'b0;
      out_enum  <= 4'h0;
      out_error <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_ACCUM: begin
          if (accept && !delim) begin
            if (cnt == 4'(MAXLEN)) begin
              ovf <= 1'b1;
            end else begin
              name_buf[{lane, 3'b000} +: 8] <= ch_byte;
              cnt <= cnt + 4'd1;
            end
          end
        end
        ST_MATCH: begin
          out_enum  <= match_code;
          out_error <= match_error;
        end
        ST_OUT: begin
          if (out_ready) begin
            name_buf <= NAME_BLANK;
            cnt      <= 4'd0;
            ovf      <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
